// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issue/collect sequencer for the ALU's registered functional units
module alu_cmd_sequencer #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IN_DATA_WIDTH-1:0]  Cmd_A,
  input  logic [IN_DATA_WIDTH-1:0]  Cmd_B,
  input  logic [3:0]                Cmd_FUN,
  input  logic                      Cmd_Valid,
  output logic                      Cmd_Ready,
  output logic [IN_DATA_WIDTH-1:0]  Unit_A,
  output logic [IN_DATA_WIDTH-1:0]  Unit_B,
  output logic [1:0]                Unit_FUNC,
  output logic                      Arith_Enable,
  output logic                      Logic_Enable,
  output logic                      CMP_Enable,
  output logic                      Shift_Enable,
  input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Shift_OUT,
  input  logic                      Arith_Flag,
  input  logic                      Logic_Flag,
  input  logic                      CMP_Flag,
  input  logic                      Shift_Flag,
  output logic [OUT_DATA_WIDTH-1:0] Res_OUT,
  output logic                      Res_Err,
  output logic                      Res_Valid,
  input  logic                      Res_Ready,
  output logic                      Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t     state;
  logic [1:0] sel;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      sel          <= 2'b00;
      Unit_A       <= '0;
      Unit_B       <= '0;
      Unit_FUNC    <= 2'b00;
      Arith_Enable <= 1'b0;
      Logic_Enable <= 1'b0;
      CMP_Enable   <= 1'b0;
      Shift_Enable <= 1'b0;
      Res_OUT      <= '0;
      Res_Err      <= 1'b0;
      Res_Valid    <= 1'b0;
      Busy         <= 1'b0;
      Cmd_Ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Cmd_Valid) begin
            Unit_A       <= Cmd_A;
            Unit_B       <= Cmd_B;
            Unit_FUNC    <= Cmd_FUN[1:0];
            sel          <= Cmd_FUN[3:2];
            // Enables are registered here so they are high for the ISSUE cycle only.
            Arith_Enable <= (Cmd_FUN[3:2] == 2'b00);
            Logic_Enable <= (Cmd_FUN[3:2] == 2'b01);
            CMP_Enable   <= (Cmd_FUN[3:2] == 2'b10);
            Shift_Enable <= (Cmd_FUN[3:2] == 2'b11);
            Cmd_Ready    <= 1'b0;
            Busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          Arith_Enable <= 1'b0;
          Logic_Enable <= 1'b0;
          CMP_Enable   <= 1'b0;
          Shift_Enable <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          // Units registered their result at the end of ISSUE; pick it up with the latched select.
          case (sel)
            2'b00: begin Res_OUT <= Arith_OUT; Res_Err <= ~Arith_Flag; end
            2'b01: begin Res_OUT <= Logic_OUT; Res_Err <= ~Logic_Flag; end
            2'b10: begin Res_OUT <= CMP_OUT;   Res_Err <= ~CMP_Flag;   end
            default: begin Res_OUT <= Shift_OUT; Res_Err <= ~Shift_Flag; end
          endcase
          Res_Valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (Res_Ready) begin
            Res_Valid <= 1'b0;
            Cmd_Ready <= 1'b1;
            Busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] Cmd_A = '0, Cmd_B = '0;
  logic [3:0]  Cmd_FUN = '0;
  logic        Cmd_Valid = 1'b0;
  logic        Cmd_Ready;
  logic [15:0] Unit_A, Unit_B;
  logic [1:0]  Unit_FUNC;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [15:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
  logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
  logic [15:0] Res_OUT;
  logic        Res_Err, Res_Valid;
  logic        Res_Ready = 1'b0;
  logic        Busy;

  bit no_flag = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .Cmd_A(Cmd_A), .Cmd_B(Cmd_B), .Cmd_FUN(Cmd_FUN), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Unit_A(Unit_A), .Unit_B(Unit_B), .Unit_FUNC(Unit_FUNC),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable), .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .Res_OUT(Res_OUT), .Res_Err(Res_Err), .Res_Valid(Res_Valid), .Res_Ready(Res_Ready), .Busy(Busy)
  );

  function automatic logic [15:0] calc(input logic [1:0] unit, input logic [1:0] fn,
                                       input logic [15:0] a, input logic [15:0] b);
    case ({unit, fn})
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return b - a;
      4'b0011: return a + b + 16'd1;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return ~(a ^ b);
      4'b1000: return {15'd0, a == b};
      4'b1001: return {15'd0, a > b};
      4'b1010: return {15'd0, a < b};
      4'b1011: return {15'd0, a != b};
      4'b1100: return a << b[3:0];
      4'b1101: return a >> b[3:0];
      4'b1110: return {a[15], a[15:1]};
      default: return {a[14:0], 1'b0};
    endcase
  endfunction

  // Registered unit models: result and one-cycle valid flag after an enable.
  always @(posedge CLK) begin
    if (Arith_Enable) Arith_OUT <= no_flag ? 16'h1234 : calc(2'b00, Unit_FUNC, Unit_A, Unit_B);
    if (Logic_Enable) Logic_OUT <= no_flag ? 16'h1234 : calc(2'b01, Unit_FUNC, Unit_A, Unit_B);
    if (CMP_Enable)   CMP_OUT   <= no_flag ? 16'h1234 : calc(2'b10, Unit_FUNC, Unit_A, Unit_B);
    if (Shift_Enable) Shift_OUT <= no_flag ? 16'h1234 : calc(2'b11, Unit_FUNC, Unit_A, Unit_B);
    Arith_Flag <= Arith_Enable & ~no_flag;
    Logic_Flag <= Logic_Enable & ~no_flag;
    CMP_Flag   <= CMP_Enable & ~no_flag;
    Shift_Flag <= Shift_Enable & ~no_flag;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] unit);
    return 4'b1000 >> unit;
  endfunction

  // One full command: accept, issue, wait, hold for `hold` cycles, release. Called at a negedge.
  task automatic do_cmd(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit nf);
    int guard = 0;
    logic [15:0] exp_out;
    while (!Cmd_Ready && guard < 20) begin @(negedge CLK); guard++; end
    chk("ready_wait", Cmd_Ready, 1);
    exp_out = nf ? 16'h1234 : calc(fun[3:2], fun[1:0], a, b);
    no_flag = nf;
    Cmd_A = a; Cmd_B = b; Cmd_FUN = fun; Cmd_Valid = 1'b1;
    @(negedge CLK);
    chk("issue_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}, onehot(fun[3:2]));
    chk("issue_ops", {Unit_A, Unit_B}, {a, b});
    chk("issue_func", Unit_FUNC, fun[1:0]);
    chk("issue_flags", {Cmd_Ready, Busy, Res_Valid}, 3'b010);
    Cmd_Valid = $urandom_range(0, 1); Cmd_A = $urandom; Cmd_FUN = $urandom; Res_Ready = $urandom_range(0, 1);
    @(negedge CLK);
    chk("wait_en", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, Res_Valid, Cmd_Ready}, 6'b0);
    @(negedge CLK);
    chk("hold_valid", Res_Valid, 1);
    chk("hold_out", Res_OUT, exp_out);
    chk("hold_err", Res_Err, nf);
    no_flag = 1'b0;
    for (int i = 0; i < hold; i++) begin
      Res_Ready = 1'b0; Cmd_Valid = $urandom_range(0, 1); Cmd_B = $urandom;
      @(negedge CLK);
      chk("bp_stable", {Res_Valid, Res_OUT, Res_Err}, {1'b1, exp_out, nf});
      chk("bp_idle", {Cmd_Ready, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, Busy}, 6'b000001);
    end
    Res_Ready = 1'b1; Cmd_Valid = 1'b0;
    @(negedge CLK);
    chk("release", {Res_Valid, Cmd_Ready, Busy}, 3'b010);
    chk("ops_held", {Unit_A, Unit_B, Unit_FUNC}, {a, b, fun[1:0]});
    Res_Ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    repeat (2) @(negedge CLK);
    chk("rst_regs", {Unit_A, Unit_B, Unit_FUNC, Res_OUT}, 50'd0);
    chk("rst_flags", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, Res_Err, Res_Valid, Busy}, 7'd0);
    chk("rst_ready", Cmd_Ready, 1);
    RST = 1'b1;
    @(negedge CLK);

    do_cmd(4'b0100, 16'hF0F0, 16'hFF00, 0, 1'b0);
    do_cmd(4'b0010, 16'h1234, 16'h0034, 2, 1'b0);
    do_cmd(4'b1001, 16'h8000, 16'h7FFF, 0, 1'b0);
    do_cmd(4'b1111, 16'h8001, 16'h0003, 1, 1'b0);
    do_cmd(4'b0001, 16'h5555, 16'h1111, 10, 1'b0);
    do_cmd(4'b1100, 16'h0F0F, 16'h0004, 0, 1'b1);

    // Back-to-back with Cmd_Valid held: second accept 4 cycles after the first.
    Res_Ready = 1'b1; Cmd_A = 16'h000F; Cmd_B = 16'h00F0; Cmd_FUN = 4'b0101; Cmd_Valid = 1'b1;
    @(negedge CLK);
    chk("b2b_en1", Logic_Enable, 1);
    Cmd_FUN = 4'b0111;
    for (int k = 2; k <= 4; k++) begin
      @(negedge CLK);
      if (k == 4) chk("b2b_ready", Cmd_Ready, 1);
      else        chk("b2b_busy", Cmd_Ready, 0);
      if (k == 3) chk("b2b_res1", Res_OUT, 16'h00FF);
    end
    @(negedge CLK);
    chk("b2b_en2", {Logic_Enable, Unit_FUNC}, 3'b111);
    Cmd_Valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("b2b_res2", {Res_Valid, Res_OUT}, {1'b1, 16'hFF00});
    @(negedge CLK);
    Res_Ready = 1'b0;

    // Randomized commands with random backpressure and occasional missing flags.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rb = $urandom;
      do_cmd(4'($urandom), ra, rb, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    // Reset during ISSUE drops everything without waiting for a clock edge.
    Cmd_A = 16'hABCD; Cmd_B = 16'h1111; Cmd_FUN = 4'b1101; Cmd_Valid = 1'b1;
    @(negedge CLK);
    chk("rst_mid_en", Shift_Enable, 1);
    Cmd_Valid = 1'b0; Res_Ready = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_drop", {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, Busy}, 5'd0);
    @(negedge CLK);
    RST = 1'b1;
    chk("rst_after", {Cmd_Ready, Res_Valid, Unit_A}, {1'b1, 1'b0, 16'h0000});
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("rst_no_stale", {Res_Valid, Busy}, 2'b00);
    end
    Res_Ready = 1'b0;
    do_cmd(4'b0110, 16'h00FF, 16'h0F0F, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue/collect stage for the 16-bit ALU's registered functional units: arithmetic, logic, compare and shift.
- Accepts one command per valid/ready handshake and decodes the 4-bit function into a one-hot unit enable plus the 2-bit unit function.
- Drives the operands to the units for exactly one issue cycle, then captures the selected unit's registered output and flag one cycle later.
- Presents the captured result on a valid/ready result port.

Parameters:
IN_DATA_WIDTH, 16, operand width A/B
OUT_DATA_WIDTH, 16, unit result and result-port width

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-low reset
Cmd_A  input  IN_DATA_WIDTH  operand A
Cmd_B  input  IN_DATA_WIDTH  operand B
Cmd_FUN  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function
Cmd_Valid  input  1  command present
Cmd_Ready  output  1  sequencer can accept a command
Unit_A  output  IN_DATA_WIDTH  operand A to all units
Unit_B  output  IN_DATA_WIDTH  operand B to all units
Unit_FUNC  output  2  function code to all units
Arith_Enable  output  1  arithmetic unit enable
Logic_Enable  output  1  logic unit enable
CMP_Enable  output  1  compare unit enable
Shift_Enable  output  1  shift unit enable
Arith_OUT / Logic_OUT / CMP_OUT / Shift_OUT  input  OUT_DATA_WIDTH each  registered unit results
Arith_Flag / Logic_Flag / CMP_Flag / Shift_Flag  input  1 each  registered unit valid flags
Res_OUT  output  OUT_DATA_WIDTH  captured result
Res_Err  output  1  selected unit flag was 0 at capture
Res_Valid  output  1  result available
Res_Ready  input  1  consumer accepts result
Busy  output  1  high in any state except IDLE

Behaviour:
- Reset (RST low, asynchronous):
  - State IDLE; Unit_A, Unit_B, Unit_FUNC, Res_OUT and the latched select cleared to 0.
  - All enables, Res_Err, Res_Valid and Busy are 0.
  - Reset asserted mid-operation abandons the command: no result is produced and enables drop immediately.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - Cmd_Ready=1.
  - On Cmd_Valid=1, latch Cmd_A→Unit_A, Cmd_B→Unit_B, Cmd_FUN[1:0]→Unit_FUNC and Cmd_FUN[3:2]→select; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - The enable decoded from select is 1; the other three are 0.
  - The units register their result at the end of this cycle; go to WAIT.
- WAIT (exactly 1 cycle):
  - All enables are 0.
  - At the end of the cycle: Res_OUT←selected unit OUT, Res_Err←~(selected unit Flag); go to HOLD.
- HOLD:
  - Res_Valid=1; Res_OUT and Res_Err stable.
  - On Res_Ready=1, go to IDLE; Res_Valid drops the next cycle.
  - Res_Ready while not in HOLD is ignored.
- Cmd_Ready is 0 outside IDLE; Cmd_Valid there is ignored and the command is not consumed.
- Unit_A, Unit_B and Unit_FUNC hold their latched values from accept until the next accept, including through HOLD and IDLE.
- Enable rules:
  - At most one enable is high in any cycle.
  - Enables are high only in ISSUE.
  - All enables are driven from registered state with no combinational path from Cmd_*.
- Latency: accept edge to Res_Valid=1 is 3 cycles (ISSUE, WAIT, then HOLD).
- Throughput: 1 command per 4 cycles when Res_Ready is held high.
- Mux select uses the latched select, never the live Cmd_FUN.
- Widths: no arithmetic inside the block; OUT_DATA_WIDTH passes through unchanged.

Test Plan:
- Logic AND: Cmd_A=16'hF0F0, Cmd_B=16'hFF00, Cmd_FUN=4'b0100, Cmd_Valid for 1 cycle → Logic_Enable=1 for exactly the cycle after accept with Unit_FUNC=2'b00; Res_Valid 3 cycles after accept; Res_OUT=16'hF000, Res_Err=0.
- Back-to-back: Cmd_Valid held high with two commands (4'b0101 A=16'h000F B=16'h00F0; then 4'b0111 same operands), Res_Ready=1 → second accept exactly 4 cycles after the first; Cmd_Ready=0 in between; results 16'h00FF then 16'hFF00.
- Backpressure: Res_Ready=0 for 10 cycles in HOLD → Res_Valid and Res_OUT stable, Cmd_Ready=0, all enables 0; Res_Ready=1 → IDLE next cycle.
- Unit select decode: Cmd_FUN=4'b0010, 4'b1001, 4'b1111 in turn → only Arith_Enable, CMP_Enable, Shift_Enable respectively pulse; Unit_FUNC=10, 01, 11; Res_OUT taken from the matching unit model.
- Missing flag: unit model returns Flag=0, OUT=16'h1234 → Res_OUT=16'h1234, Res_Err=1.
- Reset mid-op: assert RST low during ISSUE → enables drop and Busy=0 without a clock edge; after release Cmd_Ready=1, Res_Valid=0, and no stale result appears.
